// File: rtl/i2c_slave_pkg.sv
// Shared definitions for the I2C slave receive path: FSM encoding, byte width,
// default address width and the TMP10X family base address.
package i2c_slave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RECV      = 3'd1,
    ST_ACK_WAIT  = 3'd2,
    ST_ACK_DRIVE = 3'd3,
    ST_IGNORE    = 3'd4
  } state_t;

  localparam int I2C_BYTE_BITS      = 8;
  localparam int DEFAULT_ADDR_WIDTH = 7;
  localparam logic [6:0] TMP10X_BASE_ADDR = 7'h48;

endpackage

// File: rtl/i2c_glitch_filter.sv
// Two-flop synchroniser followed by a saturating run-length filter; latency 2+FILTER_DEPTH clk.
// The output only follows the input after FILTER_DEPTH consecutive differing samples.
module i2c_glitch_filter #(
  parameter int FILTER_DEPTH = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic filt
);

  logic       sync1;
  logic       sync2;
  logic [3:0] run_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      run_cnt <= '0;
      filt    <= 1'b1;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      // Any sample agreeing with the current output restarts the run.
      if (sync2 == filt) begin
        run_cnt <= '0;
      end else if (run_cnt == 4'(FILTER_DEPTH - 1)) begin
        filt    <= sync2;
        run_cnt <= '0;
      end else begin
        run_cnt <= run_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/i2c_slave_rx_frontend.sv
// I2C slave receive front end: filtered START/STOP detection, MSB-first byte shifting,
// ACK drive on the 9th clock, and address/RW extraction from the first byte after START.
module i2c_slave_rx_frontend
  import i2c_slave_pkg::*;
#(
  parameter int LENGTH       = DEFAULT_ADDR_WIDTH,
  parameter int FILTER_DEPTH = 3
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Scl,
  input  logic              SdaIn,
  output logic              SdaOe,
  input  logic              AckEnable,
  output logic [7:0]        ByteData,
  output logic              ByteValid,
  output logic              AddrPhase,
  output logic [LENGTH-1:0] Address,
  output logic              RwBit,
  output logic              StartDet,
  output logic              StopDet,
  output logic              Busy
);

  logic scl_f, sda_f;
  logic scl_q, sda_q;
  logic start_cond, stop_cond, scl_rise, scl_fall;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [6:0]  shreg, shreg_nxt;
  logic [7:0]  new_byte;

  logic [7:0]        data_nxt;
  logic              valid_nxt, aph_nxt, rw_nxt, start_nxt, stop_nxt, busy_nxt, oe_nxt;
  logic [LENGTH-1:0] addr_nxt;

  i2c_glitch_filter #(.FILTER_DEPTH(FILTER_DEPTH)) u_scl_filt (
    .clk  (Clk),
    .rst  (Rst),
    .raw  (Scl),
    .filt (scl_f)
  );

  i2c_glitch_filter #(.FILTER_DEPTH(FILTER_DEPTH)) u_sda_filt (
    .clk  (Clk),
    .rst  (Rst),
    .raw  (SdaIn),
    .filt (sda_f)
  );

  assign start_cond = scl_f & sda_q & ~sda_f;
  assign stop_cond  = scl_f & ~sda_q & sda_f;
  assign scl_rise   = scl_f & ~scl_q;
  assign scl_fall   = ~scl_f & scl_q;
  assign new_byte   = {shreg, sda_f};

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
      state     <= ST_IDLE;
      cnt       <= '0;
      shreg     <= '0;
      ByteData  <= '0;
      ByteValid <= 1'b0;
      AddrPhase <= 1'b0;
      Address   <= '0;
      RwBit     <= 1'b0;
      StartDet  <= 1'b0;
      StopDet   <= 1'b0;
      Busy      <= 1'b0;
      SdaOe     <= 1'b0;
    end else begin
      scl_q     <= scl_f;
      sda_q     <= sda_f;
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      shreg     <= shreg_nxt;
      ByteData  <= data_nxt;
      ByteValid <= valid_nxt;
      AddrPhase <= aph_nxt;
      Address   <= addr_nxt;
      RwBit     <= rw_nxt;
      StartDet  <= start_nxt;
      StopDet   <= stop_nxt;
      Busy      <= busy_nxt;
      SdaOe     <= oe_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shreg_nxt = shreg;
    data_nxt  = ByteData;
    valid_nxt = 1'b0;
    aph_nxt   = AddrPhase;
    addr_nxt  = Address;
    rw_nxt    = RwBit;
    start_nxt = 1'b0;
    stop_nxt  = 1'b0;
    busy_nxt  = Busy;
    oe_nxt    = SdaOe;

    // Bus conditions override any SCL edge seen in the same cycle.
    if (stop_cond) begin
      stop_nxt  = 1'b1;
      state_nxt = ST_IDLE;
      busy_nxt  = 1'b0;
      oe_nxt    = 1'b0;
      aph_nxt   = 1'b0;
      cnt_nxt   = '0;
    end else if (start_cond) begin
      start_nxt = 1'b1;
      state_nxt = ST_RECV;
      busy_nxt  = 1'b1;
      oe_nxt    = 1'b0;
      aph_nxt   = 1'b1;
      cnt_nxt   = '0;
    end else begin
      case (state)
        ST_RECV: begin
          if (scl_rise) begin
            shreg_nxt = new_byte[6:0];
            cnt_nxt   = cnt + 4'd1;
            if (cnt == 4'(I2C_BYTE_BITS - 1)) begin
              data_nxt  = new_byte;
              valid_nxt = 1'b1;
              if (AddrPhase) begin
                addr_nxt = new_byte[7 -: LENGTH];
                rw_nxt   = new_byte[0];
              end
              state_nxt = ST_ACK_WAIT;
            end
          end
        end
        ST_ACK_WAIT: begin
          if (scl_fall) begin
            if (AckEnable) begin
              oe_nxt    = 1'b1;
              state_nxt = ST_ACK_DRIVE;
            end else begin
              oe_nxt    = 1'b0;
              state_nxt = ST_IGNORE;
            end
          end
        end
        ST_ACK_DRIVE: begin
          if (scl_fall) begin
            oe_nxt = 1'b0;
            // A read request hands the bus over to the transmit block.
            if (AddrPhase && RwBit) begin
              state_nxt = ST_IGNORE;
            end else begin
              state_nxt = ST_RECV;
              aph_nxt   = 1'b0;
              cnt_nxt   = '0;
            end
          end
        end
        ST_IGNORE: begin
          oe_nxt = 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/i2c_slave_rx_frontend.md
Name: i2c_slave_rx_frontend

Overview:
Bit-level I2C slave receive front end. It synchronises and filters SCL/SDA, detects START and STOP, and shifts in bytes MSB-first. It drives the ACK bit, and presents the first byte after each START as a LENGTH-bit address plus an R/W bit. It sits directly upstream of the slave address-match stage: Address feeds its InputAddress, and the match result returns on AckEnable.

Parameters:
LENGTH, 7, address width delivered downstream; legal 1..7; Address = ByteData[7:8-LENGTH]
FILTER_DEPTH, 3, consecutive identical synchronised samples required before a filtered line changes; legal 1..15

Ports:
Clk  input  1  system clock; must be at least 8x the SCL rate
Rst  input  1  asynchronous, active-high reset
Scl  input  1  raw I2C clock from the pad
SdaIn  input  1  raw I2C data from the pad
SdaOe  output  1  1 = pull SDA low (open-drain enable)
AckEnable  input  1  1 = ACK the byte just received; sampled at the SCL falling edge that ends bit 8
ByteData  output  8  last complete byte received; holds until the next byte completes
ByteValid  output  1  one-Clk pulse when ByteData updates
AddrPhase  output  1  1 while the current byte is the first after START or repeated START
Address  output  LENGTH  address field of the first byte; held until the next address byte
RwBit  output  1  bit 0 of the address byte; 1 = master read
StartDet  output  1  one-Clk pulse on START or repeated START
StopDet  output  1  one-Clk pulse on STOP
Busy  output  1  1 from START until STOP

Behaviour:
- Reset (async, immediate): SdaOe=0, ByteData=0, ByteValid=0, AddrPhase=0, Address=0, RwBit=0, StartDet=0, StopDet=0, Busy=0. Filtered SCL and SDA reset to 1, bit counter to 0, FSM to IDLE.
- Input path: 2-flop synchroniser, then the glitch filter. Filter latency is 2+FILTER_DEPTH Clk. Edge detect uses registered filtered values.
- START: filtered SDA 1->0 while filtered SCL=1. STOP: filtered SDA 0->1 while filtered SCL=1.
- START/STOP detection takes priority over any SCL edge in the same cycle. Both are valid from any state.
- FSM states: IDLE, RECV, ACK_WAIT, ACK_DRIVE, IGNORE.
  - IDLE: on START go to RECV; AddrPhase=1, Busy=1, counter=0.
  - RECV: on each SCL rising edge, shift SDA in and increment the counter.
    - On the 8th bit, update ByteData and pulse ByteValid the next cycle.
    - If AddrPhase=1, Address and RwBit update in that same cycle.
    - Then go to ACK_WAIT.
  - ACK_WAIT: on the SCL falling edge, sample AckEnable. If 1, set SdaOe=1 and go to ACK_DRIVE. If 0, go to IGNORE (NACK; SDA released).
  - ACK_DRIVE: hold SdaOe=1 through the 9th SCL pulse. On the next SCL falling edge, clear SdaOe.
    - If AddrPhase=1 and RwBit=1, go to IGNORE; the transmit path belongs to a sibling tx block.
    - Otherwise go to RECV with AddrPhase=0 and counter=0.
  - IGNORE: no shifting, SdaOe=0; wait for START or STOP.
- STOP in any state: pulse StopDet, go to IDLE, Busy=0, SdaOe=0 the next cycle. A partial byte is discarded and ByteValid is not pulsed.
- Repeated START in any non-IDLE state: pulse StartDet, go to RECV with AddrPhase=1 and counter=0, clear SdaOe. A partial byte is discarded.
- Downstream timing: AckEnable must be valid no later than the SCL falling edge after ByteValid. The address-match block has at least half an SCL period to respond.
- Counter is 4 bits and never exceeds 8; no wrap-around is possible.

Decomposition:
- Shared package i2c_slave_pkg: FSM state encoding (IDLE/RECV/ACK_WAIT/ACK_DRIVE/IGNORE), I2C_BYTE_BITS=8, default address width 7, TMP10X base address 7'h48.
- Sub-module i2c_glitch_filter (synchroniser plus saturating sample counter, parameter FILTER_DEPTH, reset value 1). Instantiated once for SCL and once for SDA.

Test Plan:
1. START, byte 0x90, AckEnable=1 -> StartDet pulse, ByteValid with ByteData=0x90, Address=7'h48, RwBit=0, AddrPhase=1, SdaOe=1 for exactly the 9th SCL period. The next byte 0xA5 gives AddrPhase=0, ByteData=0xA5, ACKed.
2. START, byte 0x92, AckEnable=0 -> ByteValid, Address=7'h49, SdaOe stays 0, FSM in IGNORE. The following byte produces no ByteValid. STOP gives StopDet pulse and Busy=0.
3. START, 0x90 ACKed, 3 bits of data, repeated START, byte 0x91 -> second StartDet. The partial byte is dropped with no ByteValid. Address=7'h48, RwBit=1; after ACK, IGNORE with SdaOe=0.
4. STOP after 5 bits of the address byte -> StopDet, no ByteValid, Address keeps its previous value, Busy=0.
5. FILTER_DEPTH=3: a 2-Clk low glitch on SDA while SCL high -> no StartDet. A 3-Clk low -> StartDet. A 2-Clk SCL glitch during RECV -> counter unchanged.
6. Assert Rst during ACK_DRIVE -> SdaOe=0 in the same Clk without waiting for an edge, and all outputs at reset values. After release, a full address byte is received correctly.
